// File: rtl/animation_scheduler.sv
// Queues goal/win events and sequences them into the LED animator.
// Owns game pause and the shared LED bus between game and animation.
module animation_scheduler #(
  parameter int ANIM_CYCLES = 112,
  parameter int GAP_CYCLES  = 8,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic       BALL_CLOCK,
  input  logic       RESET,
  input  logic       ev_goal_1,
  input  logic       ev_goal_2,
  input  logic       ev_win_1,
  input  logic       ev_win_2,
  input  logic       new_game,
  input  logic [7:0] game_led,
  input  logic [7:0] anim_led,
  output logic       goal_player_1,
  output logic       goal_player_2,
  output logic       win_player_1,
  output logic       win_player_2,
  output logic [7:0] led,
  output logic       game_pause,
  output logic       busy,
  output logic       overflow,
  output logic [2:0] queue_count
);

  typedef enum logic [2:0] {
    IDLE, TRIGGER, PLAYING, GAP, GAME_OVER
  } state_t;

  localparam logic [7:0] ANIM_LOAD = 8'(ANIM_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);
  localparam logic [2:0] FULL_CNT  = 3'(QUEUE_DEPTH);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [1:0] fifo [4];
  logic [1:0] rd_ptr, wr_ptr;
  logic [2:0] count;
  logic [1:0] cur_code;
  logic [3:0] trig;

  logic       ev_vld;
  logic [1:0] ev_code;
  logic       pop, accept, full;
  logic       push, ovwr, drop, flush;

  always_comb begin
    ev_vld  = 1'b1;
    ev_code = 2'd0;
    if (ev_win_1)       ev_code = 2'd3;
    else if (ev_win_2)  ev_code = 2'd2;
    else if (ev_goal_1) ev_code = 2'd1;
    else if (ev_goal_2) ev_code = 2'd0;
    else                ev_vld  = 1'b0;
  end

  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign pop    = (state == IDLE) && (count != 3'd0);
  assign full   = (count == FULL_CNT);
  assign accept = ev_vld && (state != GAME_OVER);
  assign push   = accept && (!full || pop);
  assign drop   = accept && full && !pop;
  assign ovwr   = drop && ev_code[1];
  assign flush  = (state == GAME_OVER) && new_game;

  always_ff @(posedge BALL_CLOCK) begin
    if (push) fifo[wr_ptr] <= ev_code;
    if (ovwr) fifo[2'(wr_ptr - 2'd1)] <= ev_code;
  end

  always_ff @(posedge BALL_CLOCK) begin
    if (RESET || flush) begin
      rd_ptr   <= 2'd0;
      wr_ptr   <= 2'd0;
      count    <= 3'd0;
      overflow <= 1'b0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      if (push) wr_ptr <= wr_ptr + 2'd1;
      count <= count + {2'b0, push} - {2'b0, pop};
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge BALL_CLOCK) begin
    if (RESET) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      cur_code <= 2'd0;
      trig     <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      trig  <= 4'd0;
      if (pop) begin
        cur_code <= fifo[rd_ptr];
        trig     <= 4'd1 << fifo[rd_ptr];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: if (pop) state_nxt = TRIGGER;
      TRIGGER: begin
        cnt_nxt   = ANIM_LOAD;
        state_nxt = PLAYING;
      end
      PLAYING:
        if (cnt == 8'd0) begin
          cnt_nxt   = GAP_LOAD;
          state_nxt = GAP;
        end else cnt_nxt = cnt - 8'd1;
      GAP:
        if (cnt == 8'd0)
          state_nxt = cur_code[1] ? GAME_OVER : IDLE;
        else cnt_nxt = cnt - 8'd1;
      GAME_OVER: if (new_game) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    led = 8'h00;
    if (!RESET) begin
      unique case (state)
        IDLE:      led = game_led;
        PLAYING:   led = anim_led;
        GAME_OVER: led = cur_code[0] ? 8'hF0 : 8'h0F;
        default:   led = 8'h00;
      endcase
    end
  end

  assign win_player_1  = trig[3];
  assign win_player_2  = trig[2];
  assign goal_player_1 = trig[1];
  assign goal_player_2 = trig[0];
  assign busy          = (state != IDLE);
  assign game_pause    = busy || (count != 3'd0);
  assign queue_count   = count;

endmodule

// File: tb/tb_animation_scheduler.sv
// Directed bench for animation_scheduler.
// Exercises sequencing, queueing, overflow, game over and reset.
module tb_animation_scheduler;

  logic       clk = 1'b0;
  logic       RESET;
  logic       ev_goal_1, ev_goal_2, ev_win_1, ev_win_2;
  logic       new_game;
  logic [7:0] game_led, anim_led;
  logic       goal_player_1, goal_player_2;
  logic       win_player_1, win_player_2;
  logic [7:0] led;
  logic       game_pause, busy, overflow;
  logic [2:0] queue_count;
  logic [3:0] trg;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [7:0] GLED = 8'hA5;
  localparam logic [7:0] ALED = 8'h3C;

  animation_scheduler dut (
    .BALL_CLOCK   (clk),
    .RESET        (RESET),
    .ev_goal_1    (ev_goal_1),
    .ev_goal_2    (ev_goal_2),
    .ev_win_1     (ev_win_1),
    .ev_win_2     (ev_win_2),
    .new_game     (new_game),
    .game_led     (game_led),
    .anim_led     (anim_led),
    .goal_player_1(goal_player_1),
    .goal_player_2(goal_player_2),
    .win_player_1 (win_player_1),
    .win_player_2 (win_player_2),
    .led          (led),
    .game_pause   (game_pause),
    .busy         (busy),
    .overflow     (overflow),
    .queue_count  (queue_count)
  );

  always #5 clk = ~clk;

  assign trg = {win_player_1, win_player_2,
                goal_player_1, goal_player_2};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, output int hits);
    hits = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (trg != 4'd0) hits++;
    end
  endtask

  task automatic wait_trig(output logic [3:0] v,
                           output int cyc,
                           output logic pause_ok);
    cyc = 0;
    pause_ok = 1'b1;
    do begin
      tick();
      cyc++;
      if (!game_pause) pause_ok = 1'b0;
    end while (trg == 4'd0 && cyc < 300);
    v = trg;
  endtask

  task automatic pulse_goal_1();
    ev_goal_1 = 1'b1;
    tick();
    ev_goal_1 = 1'b0;
  endtask

  initial begin
    int         bad, hits, cyc;
    logic [3:0] v;
    logic       pok;
    logic [3:0] exp_seq [4];
    exp_seq[0] = 4'b0001;
    exp_seq[1] = 4'b0001;
    exp_seq[2] = 4'b0001;
    exp_seq[3] = 4'b0100;

    RESET = 1'b1;
    {ev_goal_1, ev_goal_2, ev_win_1, ev_win_2} = 4'b0;
    new_game = 1'b0;
    game_led = GLED;
    anim_led = ALED;
    tick();
    tick();
    chk("rst_led", led, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_pause", game_pause, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_cnt", queue_count, 0);
    chk("rst_trig", trg, 0);
    RESET = 1'b0;
    #1;
    chk("idle_led", led, GLED);

    // Single goal: full timeline
    pulse_goal_1();
    chk("t1_pause_c1", game_pause, 1);
    chk("t1_cnt_c1", queue_count, 1);
    chk("t1_trig_c1", trg, 0);
    tick();
    chk("t1_trig_c2", trg, 4'b0010);
    chk("t1_led_c2", led, 8'h00);
    chk("t1_cnt_c2", queue_count, 0);
    tick();
    bad = 0;
    hits = 0;
    for (int c = 3; c <= 122; c++) begin
      if (led !== ((c <= 114) ? ALED : 8'h00)) bad++;
      if (trg != 4'd0) hits++;
      if (!game_pause) bad++;
      tick();
    end
    chk("t1_led_window", bad, 0);
    chk("t1_extra_trig", hits, 0);
    chk("t1_led_c123", led, GLED);
    chk("t1_busy_c123", busy, 0);
    chk("t1_pause_c123", game_pause, 0);

    // Simultaneous goal_2 + win_1: only W1
    ev_goal_2 = 1'b1;
    ev_win_1  = 1'b1;
    tick();
    ev_goal_2 = 1'b0;
    ev_win_1  = 1'b0;
    chk("t2_cnt", queue_count, 1);
    tick();
    chk("t2_trig", trg, 4'b1000);
    run(121, hits);
    chk("t2_no_more_trig", hits, 0);
    chk("t2_ovf", overflow, 0);
    chk("t2_busy", busy, 1);
    chk("t2_led_over", led, 8'hF0);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    chk("t2_exit_busy", busy, 0);

    // Five goals while playing, then win_2 on full queue
    pulse_goal_1();
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 5; i++) begin
      ev_goal_2 = 1'b1;
      tick();
      ev_goal_2 = 1'b0;
      chk("t3_cnt", queue_count, (i < 3) ? i + 1 : 4);
      if (i == 3) chk("t3_ovf_not_yet", overflow, 0);
    end
    chk("t3_ovf", overflow, 1);
    ev_win_2 = 1'b1;
    tick();
    ev_win_2 = 1'b0;
    chk("t3_cnt_full", queue_count, 4);
    chk("t3_ovf_win", overflow, 1);
    for (int k = 0; k < 4; k++) begin
      wait_trig(v, cyc, pok);
      chk("t3_drain_code", v, exp_seq[k]);
      chk("t3_pause_held", pok, 1);
      if (k > 0) chk("t4_spacing", cyc, 122);
    end
    run(121, hits);
    chk("t3_no_extra", hits, 0);
    chk("t3_busy_over", busy, 1);
    chk("t3_led_over", led, 8'h0F);

    // Game over: events ignored, new_game clears
    pulse_goal_1();
    chk("t5_cnt_ignored", queue_count, 0);
    chk("t5_ovf_kept", overflow, 1);
    chk("t5_led_over", led, 8'h0F);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_cnt", queue_count, 0);
    chk("t5_ovf_clr", overflow, 0);
    chk("t5_led", led, GLED);
    run(5, hits);
    chk("t5_no_trig", hits, 0);

    // Reset mid-animation with two queued
    pulse_goal_1();
    for (int i = 0; i < 4; i++) tick();
    ev_goal_2 = 1'b1;
    tick();
    tick();
    ev_goal_2 = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("t6_cnt_pre", queue_count, 2);
    chk("t6_led_play", led, ALED);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_cnt", queue_count, 0);
    chk("t6_pause", game_pause, 0);
    chk("t6_led", led, GLED);
    run(300, hits);
    chk("t6_no_trig", hits, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/animation_scheduler.md
Name: animation_scheduler

Overview:
Sequences goal/win events from the scoring logic into the LED animation block. Queues events in a small FIFO and issues one-cycle trigger pulses to the animator, one event at a time. Times each animation, pauses the game while it runs, and multiplexes the shared 8-bit LED bus between game display and animation output. Sits between score/ball logic and the animation block; all logic runs in the BALL_CLOCK domain.

Parameters:
ANIM_CYCLES, 112, BALL_CLOCK cycles one animation occupies after its trigger pulse (covers 3 repetitions x 9 steps x 4 cycles plus margin).
GAP_CYCLES, 8, blank cycles (led = 0) between consecutive animations.
QUEUE_DEPTH, 4, event FIFO entries; fixed at 4 (pointer width 2).

Ports:
BALL_CLOCK  input  1  sole clock, all logic on posedge.
RESET  input  1  synchronous, active-high reset.
ev_goal_1  input  1  player 1 scored; single-cycle pulse.
ev_goal_2  input  1  player 2 scored; single-cycle pulse.
ev_win_1  input  1  player 1 won the match; single-cycle pulse.
ev_win_2  input  1  player 2 won the match; single-cycle pulse.
new_game  input  1  leave GAME_OVER; flush queue.
game_led  input  8  ball-position LED pattern from game logic.
anim_led  input  8  LED output of the animation block.
goal_player_1  output  1  trigger pulse to animator.
goal_player_2  output  1  trigger pulse to animator.
win_player_1  output  1  trigger pulse to animator.
win_player_2  output  1  trigger pulse to animator.
led  output  8  muxed LED bus to the pins.
game_pause  output  1  freezes ball/paddle logic.
busy  output  1  state != IDLE.
overflow  output  1  sticky: an event was dropped.
queue_count  output  3  FIFO occupancy, 0..4.

Behaviour:
- Reset (synchronous): state IDLE; FIFO empty; all triggers 0; led = 0 for the reset cycle; game_pause 0; busy 0; overflow 0; queue_count 0. Reset overrides everything, including mid-animation.
- Event encoding: 2-bit code W1=3, W2=2, G1=1, G2=0. Priority when several ev_* are high in one cycle: W1 > W2 > G1 > G2. Only the winner is enqueued; the others are discarded without setting overflow.
- Enqueue: an event at edge t is visible in queue_count after edge t. A simultaneous pop and push in one cycle is legal; count is unchanged.
- FIFO full plus a goal event: the event is dropped and overflow is set.
- FIFO full plus a win event: the newest entry is overwritten with the win and overflow is set.
- Events arriving in GAME_OVER are ignored; overflow is not set.
- State machine:
  - IDLE: led = game_led. If the FIFO is non-empty, pop the head into cur_code and go to TRIGGER.
  - TRIGGER (1 cycle): assert exactly one trigger output matching cur_code; led = 0. Load the counter with ANIM_CYCLES-1 and go to PLAYING.
  - PLAYING: led = anim_led. Decrement the counter; at 0, load GAP_CYCLES-1 and go to GAP.
  - GAP: led = 0. Decrement the counter; at 0, go to GAME_OVER if cur_code is a win, else IDLE.
  - GAME_OVER: led = 8'b11110000 (P1 won) or 8'b00001111 (P2 won). Stays until new_game. new_game flushes the FIFO, clears overflow, and returns to IDLE.
  - new_game outside GAME_OVER: no effect.
- Timing: trigger pulses are registered. A trigger rises on the edge after the pop, i.e. 2 cycles after the event pulse when the block is idle with an empty queue.
- game_pause = (state != IDLE) or (queue_count != 0). It is asserted on the edge after the event is enqueued.
- The counter is 8 bits wide; ANIM_CYCLES and GAP_CYCLES must each be between 1 and 256.
- Trigger outputs are never high for more than one consecutive cycle. At most one trigger is high at any time.

Test Plan:
1. Reset, then ev_goal_1 pulse at cycle 0: goal_player_1 high for exactly cycle 2 only; game_pause rises at cycle 1; led = anim_led for cycles 3..114; led = 0 for cycles 115..122; IDLE with led = game_led from cycle 123.
2. ev_goal_2 and ev_win_1 high in the same cycle: only W1 is queued (queue_count = 1); win_player_1 pulses; no goal trigger appears; ends in GAME_OVER with led = 8'hF0.
3. Five goal events on consecutive cycles while PLAYING: queue_count saturates at 4; overflow = 1. Then ev_win_2 with the queue full: the last entry becomes W2. Drain order is G,G,G,W2; the final state is GAME_OVER with led = 8'h0F.
4. Two queued goals: trigger pulses are spaced exactly 1+ANIM_CYCLES+GAP_CYCLES+1 = 122 cycles apart; game_pause stays high continuously in between.
5. In GAME_OVER: ev_goal_1 is ignored (queue_count stays 0). new_game gives IDLE the next cycle; queue_count = 0; overflow = 0; led = game_led.
6. RESET asserted in mid-PLAYING with 2 entries queued: the next cycle shows state IDLE, queue_count 0, game_pause 0, and no trigger pulse afterwards without a new event.
